// File: rtl/space_invaders_pkg.sv
// Shared types and default constants for the enemy formation controller.
package space_invaders_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        MARCH   = 3'd2,
        DESCEND = 3'd3,
        CLEARED = 3'd4,
        OVER    = 3'd5
    } formation_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int             DEF_NUM_ENEMIES  = 24;
    localparam logic [9:0]     DEF_INIT_X       = 10'd40;
    localparam logic [9:0]     DEF_INIT_Y       = 10'd48;
    localparam logic [9:0]     DEF_FORM_W       = 10'd400;
    localparam logic [9:0]     DEF_FORM_H       = 10'd180;
    localparam logic [9:0]     DEF_LEFT_LIMIT   = 10'd8;
    localparam logic [9:0]     DEF_RIGHT_LIMIT  = 10'd632;
    localparam logic [9:0]     DEF_BOTTOM_LIMIT = 10'd440;
    localparam int             DEF_STEP_X       = 4;
    localparam int             DEF_STEP_Y       = 12;
    localparam logic [5:0]     DEF_PERIOD_INIT  = 6'd30;
    localparam logic [5:0]     DEF_PERIOD_MIN   = 6'd2;
    localparam int             DEF_SPEEDUP      = 1;
    localparam int             DEF_WAVE_GAP     = 60;

endpackage

// File: rtl/step_timer.sv
// Frame-tick counter that fires a step event once every `period` frames.
module step_timer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       clear,
    input  logic [5:0] period,
    output logic       step_evt
);
    logic [5:0] tick;
    logic       at_terminal;

    // >= rather than == so a period that shrinks below the tick fires at once
    assign at_terminal = ({1'b0, tick} >= ({1'b0, period} - 7'd1));
    assign step_evt    = enable && frame_tick && at_terminal;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tick <= '0;
        end else if (clear) begin
            tick <= '0;
        end else if (enable && frame_tick) begin
            tick <= at_terminal ? 6'd0 : tick + 6'd1;
        end
    end
endmodule

// File: rtl/enemy_formation_ctrl.sv
// Formation march sequencer: bounces, descents, kill speed-up, wave clear and invasion.
//   state   | meaning
//   IDLE    | waiting for game_start after reset
//   LAUNCH  | one cycle: reload formation, pulse start
//   MARCH   | horizontal stepping
//   DESCEND | wall reached; next step drops one row and reverses
//   CLEARED | wave destroyed, waiting WAVE_GAP frames
//   OVER    | invasion or player death, waiting for game_start
module enemy_formation_ctrl
    import space_invaders_pkg::*;
#(
    parameter int         NUM_ENEMIES  = DEF_NUM_ENEMIES,
    parameter logic [9:0] INIT_X       = DEF_INIT_X,
    parameter logic [9:0] INIT_Y       = DEF_INIT_Y,
    parameter logic [9:0] FORM_W       = DEF_FORM_W,
    parameter logic [9:0] FORM_H       = DEF_FORM_H,
    parameter logic [9:0] LEFT_LIMIT   = DEF_LEFT_LIMIT,
    parameter logic [9:0] RIGHT_LIMIT  = DEF_RIGHT_LIMIT,
    parameter logic [9:0] BOTTOM_LIMIT = DEF_BOTTOM_LIMIT,
    parameter int         STEP_X       = DEF_STEP_X,
    parameter int         STEP_Y       = DEF_STEP_Y,
    parameter logic [5:0] PERIOD_INIT  = DEF_PERIOD_INIT,
    parameter logic [5:0] PERIOD_MIN   = DEF_PERIOD_MIN,
    parameter int         SPEEDUP      = DEF_SPEEDUP,
    parameter int         WAVE_GAP     = DEF_WAVE_GAP,
    localparam int        AW           = $clog2(NUM_ENEMIES + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_tick,
    input  logic          game_start,
    input  logic          enemy_hit,
    input  logic          player_dead,
    output logic          enemy_direction_X,
    output logic          enemy_direction_Y,
    output logic          start,
    output logic          is_playing,
    output logic          delete_enemies,
    output logic          step,
    output logic [9:0]    formation_x,
    output logic [9:0]    formation_y,
    output logic [AW-1:0] alive_count,
    output logic [7:0]    wave_num,
    output logic          game_over
);
    formation_state_t state, state_nxt;
    logic [5:0] period;
    logic [7:0] gap_cnt;
    logic       playing, step_evt, kill, final_kill, step_go;
    logic       hit_right, hit_left, invade;
    logic [9:0] y_next;

    assign playing    = (state == MARCH) || (state == DESCEND);
    assign kill       = playing && enemy_hit && !player_dead;
    assign final_kill = kill && (alive_count == AW'(1));
    assign step_go    = step_evt && !player_dead && !final_kill;

    assign hit_right = enemy_direction_X &&
                       ((11'(formation_x) + 11'(FORM_W) + 11'(STEP_X)) > 11'(RIGHT_LIMIT));
    assign hit_left  = !enemy_direction_X && (formation_x < (LEFT_LIMIT + 10'(STEP_X)));
    assign y_next    = formation_y + 10'(STEP_Y);
    assign invade    = (11'(y_next) + 11'(FORM_H)) >= 11'(BOTTOM_LIMIT);

    step_timer u_step_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .enable     (playing),
        .clear      (state == LAUNCH),
        .period     (period),
        .step_evt   (step_evt)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (game_start) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = MARCH;
            MARCH, DESCEND: begin
                if (player_dead)     state_nxt = OVER;
                else if (final_kill) state_nxt = CLEARED;
                else if (step_go) begin
                    if (state == MARCH) begin
                        if (hit_right || hit_left) state_nxt = DESCEND;
                    end else begin
                        state_nxt = invade ? OVER : MARCH;
                    end
                end
            end
            CLEARED: if (frame_tick && (gap_cnt == 8'(WAVE_GAP - 1))) state_nxt = LAUNCH;
            OVER:    if (game_start) state_nxt = LAUNCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state             <= IDLE;
            formation_x       <= INIT_X;
            formation_y       <= INIT_Y;
            enemy_direction_X <= 1'b1;
            enemy_direction_Y <= 1'b0;
            start             <= 1'b0;
            step              <= 1'b0;
            delete_enemies    <= 1'b0;
            is_playing        <= 1'b0;
            game_over         <= 1'b0;
            alive_count       <= AW'(NUM_ENEMIES);
            wave_num          <= 8'd0;
            period            <= PERIOD_INIT;
            gap_cnt           <= 8'd0;
        end else begin
            state          <= state_nxt;
            start          <= (state_nxt == LAUNCH);
            is_playing     <= (state_nxt == MARCH) || (state_nxt == DESCEND);
            game_over      <= (state_nxt == OVER);
            delete_enemies <= ((state_nxt == CLEARED) && (state != CLEARED)) ||
                              ((state_nxt == OVER) && (state != OVER));
            step           <= step_go;
            gap_cnt        <= (state != CLEARED) ? 8'd0 : (frame_tick ? gap_cnt + 8'd1 : gap_cnt);

            if (state_nxt == LAUNCH) begin
                formation_x       <= INIT_X;
                formation_y       <= INIT_Y;
                enemy_direction_X <= 1'b1;
                enemy_direction_Y <= 1'b0;
                alive_count       <= AW'(NUM_ENEMIES);
                period            <= PERIOD_INIT;
                if (state == OVER)         wave_num <= 8'd0;
                else if (state == CLEARED) wave_num <= wave_num + 8'd1;
            end else begin
                if (kill) begin
                    alive_count <= (alive_count == '0) ? '0 : alive_count - AW'(1);
                    if ({1'b0, period} >= (7'(PERIOD_MIN) + 7'(SPEEDUP)))
                        period <= period - 6'(SPEEDUP);
                    else
                        period <= PERIOD_MIN;
                end
                if (step_go) begin
                    if (state == MARCH) begin
                        if (hit_right || hit_left)  enemy_direction_Y <= 1'b1;
                        else if (enemy_direction_X) formation_x <= formation_x + 10'(STEP_X);
                        else                        formation_x <= formation_x - 10'(STEP_X);
                    end else begin
                        formation_y       <= y_next;
                        enemy_direction_X <= ~enemy_direction_X;
                        enemy_direction_Y <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// Directed bench for enemy_formation_ctrl: a default 24-enemy instance and a 30-enemy instance.
module tb_enemy_formation_ctrl;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic frame_tick = 1'b0, game_start = 1'b0, hit = 1'b0, hit30 = 1'b0, player_dead = 1'b0;

    logic       dir_x, dir_y, start, is_playing, del, step, over;
    logic [9:0] fx, fy;
    logic [4:0] alive;
    logic [7:0] wave;

    logic       dir_x30, dir_y30, start30, is_playing30, del30, step30, over30;
    logic [9:0] fx30, fy30;
    logic [4:0] alive30;
    logic [7:0] wave30;

    int checks = 0, errors = 0;
    int start_cnt = 0, del_cnt = 0, step_cnt = 0, del_cnt30 = 0, step_cnt30 = 0;

    always #5 Clk = ~Clk;

    enemy_formation_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .game_start(game_start),
        .enemy_hit(hit), .player_dead(player_dead),
        .enemy_direction_X(dir_x), .enemy_direction_Y(dir_y), .start(start),
        .is_playing(is_playing), .delete_enemies(del), .step(step),
        .formation_x(fx), .formation_y(fy), .alive_count(alive), .wave_num(wave),
        .game_over(over)
    );

    enemy_formation_ctrl #(.NUM_ENEMIES(30)) dut30 (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .game_start(game_start),
        .enemy_hit(hit30), .player_dead(player_dead),
        .enemy_direction_X(dir_x30), .enemy_direction_Y(dir_y30), .start(start30),
        .is_playing(is_playing30), .delete_enemies(del30), .step(step30),
        .formation_x(fx30), .formation_y(fy30), .alive_count(alive30), .wave_num(wave30),
        .game_over(over30)
    );

    always @(posedge Clk) begin
        if (start)  start_cnt  <= start_cnt + 1;
        if (del)    del_cnt    <= del_cnt + 1;
        if (step)   step_cnt   <= step_cnt + 1;
        if (del30)  del_cnt30  <= del_cnt30 + 1;
        if (step30) step_cnt30 <= step_cnt30 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame_tick cycle, optional kills in the same cycle, then a settling cycle.
    task automatic frame(input logic k, input logic k30);
        @(negedge Clk); frame_tick = 1'b1; hit = k; hit30 = k30;
        @(negedge Clk); frame_tick = 1'b0; hit = 1'b0; hit30 = 1'b0;
        @(negedge Clk);
    endtask

    task automatic kill_pulse(input logic k, input logic k30);
        @(negedge Clk); hit = k; hit30 = k30;
        @(negedge Clk); hit = 1'b0; hit30 = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge Clk); game_start = 1'b1;
        @(negedge Clk); game_start = 1'b0;
        @(negedge Clk);
    endtask

    task automatic frames_to_step30(output int nf);
        int c0;
        c0 = step_cnt30;
        nf = 0;
        while (step_cnt30 == c0 && nf < 64) begin
            frame(1'b0, 1'b0);
            nf++;
        end
    endtask

    initial begin
        int nf, sc, px, py, y_before, c0;

        // reset values
        @(negedge Clk);
        chk("rst_x", fx, 40);            chk("rst_y", fy, 48);
        chk("rst_dir_x", dir_x, 1);      chk("rst_dir_y", dir_y, 0);
        chk("rst_playing", is_playing, 0); chk("rst_over", over, 0);
        chk("rst_alive", alive, 24);     chk("rst_wave", wave, 0);
        chk("rst_start", start, 0);      chk("rst_del", del, 0);
        Reset = 1'b1;
        repeat (5) @(negedge Clk);
        chk("idle_hold_playing", is_playing, 0);
        chk("idle_hold_start", start_cnt, 0);

        // launch and first steps at period 30
        start_pulse();
        chk("launch_start_once", start_cnt, 1);
        chk("launch_playing", is_playing, 1);
        repeat (29) frame(1'b0, 1'b0);
        chk("no_step_29", step_cnt, 0);
        chk("x_29", fx, 40);
        frame(1'b0, 1'b0);
        chk("first_step", step_cnt, 1);
        chk("x_30", fx, 44);
        repeat (30) frame(1'b0, 1'b0);
        chk("x_60", fx, 48);

        // right bounce: 232+400+4 > 632 while 228+400+4 is not
        for (int i = 0; i < 4000 && !dir_y; i++) frame(1'b0, 1'b0);
        chk("bounce_dir_y", dir_y, 1);
        chk("bounce_x", fx, 232);
        chk("bounce_y", fy, 48);
        for (int i = 0; i < 100 && dir_y; i++) frame(1'b0, 1'b0);
        chk("descend_y", fy, 60);
        chk("descend_dir_x", dir_x, 0);
        chk("descend_dir_y", dir_y, 0);
        chk("descend_x", fx, 232);

        // 24 kills clear the default wave; the 30-enemy copy keeps 6
        for (int i = 0; i < 24; i++) kill_pulse(1'b1, 1'b1);
        @(negedge Clk);
        chk("clear_alive", alive, 0);
        chk("clear_playing", is_playing, 0);
        chk("clear_del_once", del_cnt, 1);
        chk("clear_not_over", over, 0);
        chk("alive30_after24", alive30, 6);
        repeat (59) frame(1'b0, 1'b0);
        chk("gap59_no_start", start_cnt, 1);
        chk("gap59_wave", wave, 0);
        frame(1'b0, 1'b0);
        chk("gap60_start", start_cnt, 2);
        chk("gap60_wave", wave, 1);
        chk("relaunch_alive", alive, 24);
        chk("relaunch_x", fx, 40);

        // period after 24 kills is 6 frames
        frames_to_step30(nf);
        frames_to_step30(nf);
        chk("period_6", nf, 6);

        // 28 kills -> period 2; a 29th kill on a step cycle applies both, period stays 2
        for (int i = 0; i < 4; i++) kill_pulse(1'b0, 1'b1);
        chk("alive30_2", alive30, 2);
        frames_to_step30(nf);
        frames_to_step30(nf);
        chk("period_2", nf, 2);
        sc = step_cnt30;
        frame(1'b0, 1'b0);
        chk("p2_no_step", step_cnt30, sc);
        frame(1'b0, 1'b1);
        chk("kill_step_step", step_cnt30, sc + 1);
        chk("kill_step_alive", alive30, 1);
        frames_to_step30(nf);
        chk("period_clamp_2", nf, 2);

        // final kill on a step cycle: clear wins, formation does not move
        frame(1'b0, 1'b0);
        sc = step_cnt30; px = fx30; py = fy30;
        frame(1'b0, 1'b1);
        chk("final_kill_no_step", step_cnt30, sc);
        chk("final_kill_x", fx30, px);
        chk("final_kill_y", fy30, py);
        chk("final_kill_alive", alive30, 0);
        chk("final_kill_del", del_cnt30, 1);

        // invasion: speed the default instance up, then descend until it lands
        for (int i = 0; i < 23; i++) kill_pulse(1'b1, 1'b0);
        chk("inv_alive", alive, 1);
        y_before = fy;
        for (int i = 0; i < 9000 && !over; i++) begin
            y_before = fy;
            frame(1'b0, 1'b0);
        end
        chk("inv_over", over, 1);
        chk("inv_last_y", y_before, 252);
        chk("inv_playing", is_playing, 0);
        chk("inv_del", del_cnt, 2);

        // relaunch from OVER clears game_over and wave_num; game_start while marching is ignored
        start_pulse();
        chk("restart_over", over, 0);
        chk("restart_wave", wave, 0);
        chk("restart_start", start_cnt, 3);
        chk("restart_playing", is_playing, 1);
        start_pulse();
        chk("start_ignored", start_cnt, 3);

        // player death goes to OVER in one cycle
        @(negedge Clk); player_dead = 1'b1;
        @(negedge Clk); player_dead = 1'b0;
        chk("dead_over", over, 1);
        chk("dead_playing", is_playing, 0);
        @(negedge Clk);
        chk("dead_del", del_cnt, 3);

        // asynchronous reset mid-march
        start_pulse();
        repeat (35) frame(1'b0, 1'b0);
        chk("pre_reset_x", fx, 44);
        @(negedge Clk); #2 Reset = 1'b0; #1;
        chk("arst_x", fx, 40);           chk("arst_y", fy, 48);
        chk("arst_dir_x", dir_x, 1);     chk("arst_dir_y", dir_y, 0);
        chk("arst_playing", is_playing, 0);
        chk("arst_alive", alive, 24);    chk("arst_wave", wave, 0);
        chk("arst_step", step, 0);       chk("arst_start", start, 0);
        @(negedge Clk); Reset = 1'b1;
        c0 = start_cnt;
        repeat (4) frame(1'b0, 1'b0);
        chk("post_reset_idle", is_playing, 0);
        chk("post_reset_no_start", start_cnt, c0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
